fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 The module SHALL use a single clock; reset is synchronous and active-high.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock.
REQ-004 The module SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The module SHALL have port stall_f  input  1  hold PC.
REQ-006 The module SHALL have port stall_d  input  1  hold IF/ID register.
REQ-007 The module SHALL have port flush_d  input  1  bubble IF/ID register.
REQ-008 The module SHALL have port pc_src_d  input  1  branch taken, resolved in decode.
REQ-009 The module SHALL have port pc_branch_d  input  32  branch target from decode.
REQ-010 The module SHALL have port jump_d  input  1  jump decoded in decode.
REQ-011 The module SHALL have port instr_f  input  32  instruction-memory read data for pc_f, combinational.
REQ-012 The module SHALL have port pc_f  output  32  fetch address to instruction memory.
REQ-013 The module SHALL have port instr_d  output  32  IF/ID instruction; bits [31:26] feed the main decoder op.
REQ-014 The module SHALL have port pc_plus4_d  output  32  IF/ID PC+4.
REQ-015 The module SHALL have port valid_d  output  1  IF/ID holds a real instruction, not a bubble.

Function
REQ-016 The module SHALL compute pc_plus4_f as pc_f + 4, modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-017 The module SHALL compute jump_target as {pc_plus4_d[31:28], instr_d[25:0], 2'b00}, taken from the IF/ID contents.
REQ-018 The module SHALL select next PC by priority: jump_d -> jump_target; else pc_src_d -> pc_branch_d; else pc_plus4_f.
REQ-019 When stall_f = 1, pc_f SHALL hold, and jump_d and pc_src_d SHALL be ignored that cycle.
REQ-020 When stall_f = 0, pc_f SHALL load the next PC each rising edge.
REQ-021 The IF/ID register SHALL follow this priority: reset, then stall_d (hold all three fields), then flush_d (bubble), else capture.
REQ-022 Capture SHALL load instr_d <= instr_f, pc_plus4_d <= pc_plus4_f, valid_d <= 1.
REQ-023 A bubble SHALL load instr_d <= NOP_INSTR (32'h0000_0000), pc_plus4_d <= 0, valid_d <= 0.
REQ-024 When stall_d and flush_d are both 1, the hold SHALL win.
REQ-025 Branch/jump latency SHALL be as follows: a redirect asserted in cycle N SHALL make pc_f equal the target in cycle N+1.
REQ-026 The wrong-path instruction fetched in cycle N SHALL be discarded only through flush_d in cycle N, which the hazard unit drives.
REQ-027 Sequential fetch SHALL have single-cycle throughput: an instruction present at instr_f in cycle N SHALL appear on instr_d in cycle N+1.
REQ-028 No output SHALL depend combinationally on instr_f except through registers; pc_f SHALL be a register output.

Reset
REQ-029 reset SHALL be synchronous and active-high, and SHALL override stall_f, stall_d and flush_d.
REQ-030 On reset: pc_f = RESET_PC, instr_d = NOP_INSTR, pc_plus4_d = 0, valid_d = 0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending redirect.
REQ-032 The first cycle after reset is released SHALL fetch RESET_PC.

Structure
REQ-033 NOP_INSTR, DEFAULT_RESET_PC and the data width (32) SHALL live in the shared package mips_pkg.
REQ-034 A generic register sub-module flopenrc (enable, synchronous clear, parameterised width) SHALL be instantiated for the PC and the IF/ID fields.
REQ-035 All next-PC muxing SHALL be local combinational logic.

Verification
REQ-036 Reset, then free-run with instr_f = 32'h2008_0005 -> pc_f sequence 0, 4, 8; instr_d = 32'h2008_0005, valid_d = 1 from the second cycle.
REQ-037 At pc_f = 8: pc_src_d = 1, pc_branch_d = 32'h40, flush_d = 1 -> next cycle pc_f = 32'h40, instr_d = 0, valid_d = 0.
REQ-038 With instr_d = 32'h0800_0010 and pc_plus4_d = 32'h1000_0008: jump_d = 1, pc_src_d = 1 -> pc_f = 32'h1000_0040 (jump wins).
REQ-039 stall_f = stall_d = flush_d = 1 for 3 cycles -> pc_f, instr_d, pc_plus4_d and valid_d unchanged throughout.
REQ-040 Force pc_f = 32'hFFFF_FFFC, then step once -> pc_f = 0, pc_plus4_d = 0.
REQ-041 Assert reset during a stall with jump_d = 1 -> pc_f = RESET_PC and valid_d = 0 on the next edge; the jump is not taken.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  // All-zero word decodes as sll $0,$0,0, a harmless bubble.
  localparam word_t NOP_INSTR        = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // J-type target: upper nibble of the sequential PC, 26-bit index, word aligned.
  function automatic word_t jump_target(input word_t pc_plus4, input word_t instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/flopenrc.sv
// Generic register with enable and synchronous clear.
// Latency: one cycle from d to q.
// Backpressure: en low holds q and also masks clear, so a hold beats a clear.
module flopenrc #(
  parameter int unsigned   WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: hold unless enabled; when enabled, clear wins over load.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (clear) q_d = '0;
      else       q_d = d;
    end
  end

  // State register; synchronous reset overrides enable and clear.
  always_ff @(posedge clk) begin
    if (reset) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID pipeline register.
// Latency: redirect in cycle N shows on pc_f in N+1; instr_f reaches instr_d one cycle later.
// Backpressure: stall_f freezes the PC (redirects ignored), stall_d freezes IF/ID and beats flush_d.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              pc_src_d,
  input  logic [DATA_W-1:0] pc_branch_d,
  input  logic              jump_d,
  input  logic [DATA_W-1:0] instr_f,
  output logic [DATA_W-1:0] pc_f,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_plus4_d,
  output logic              valid_d
);

  word_t pc_plus4_f;
  word_t jump_tgt;
  word_t pc_next;

  // Sequential address wraps naturally at 2^32; jump target comes from IF/ID contents.
  always_comb begin
    pc_plus4_f = pc_f + 32'd4;
    jump_tgt   = jump_target(pc_plus4_d, instr_d);
  end

  // Next-PC priority: jump, then taken branch, then fall-through.
  always_comb begin
    pc_next = pc_plus4_f;
    if (jump_d)        pc_next = jump_tgt;
    else if (pc_src_d) pc_next = pc_branch_d;
  end

  flopenrc #(.WIDTH(DATA_W), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_f),
    .clear (1'b0),
    .d     (pc_next),
    .q     (pc_f)
  );

  flopenrc #(.WIDTH(DATA_W), .RST_VAL(NOP_INSTR)) u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_d),
    .clear (flush_d),
    .d     (instr_f),
    .q     (instr_d)
  );

  flopenrc #(.WIDTH(DATA_W), .RST_VAL('0)) u_pc4_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_d),
    .clear (flush_d),
    .d     (pc_plus4_f),
    .q     (pc_plus4_d)
  );

  flopenrc #(.WIDTH(1), .RST_VAL(1'b0)) u_valid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall_d),
    .clear (flush_d),
    .d     (1'b1),
    .q     (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table plus hand sequences, checked through an expectation queue.
// Latency: each vector is driven at negedge and checked 1 time unit after the next posedge.
// Backpressure: stall/flush patterns are part of the vectors.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, pc_src_d, jump_d;
  logic [31:0] pc_branch_d, instr_f;
  logic [31:0] pc_f, instr_d, pc_plus4_d;
  logic        valid_d;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pc_src_d   (pc_src_d),
    .pc_branch_d(pc_branch_d),
    .jump_d     (jump_d),
    .instr_f    (instr_f),
    .pc_f       (pc_f),
    .instr_d    (instr_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, sf, sd, fd, src, jmp;
    logic [31:0] br, ins;
    logic [31:0] e_pc, e_ins, e_pp4;
    logic        e_v;
  } vec_t;

  typedef struct {
    logic [31:0] pc, ins, pp4;
    logic        v;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rst, input logic sf, input logic sd, input logic fd,
                              input logic src, input logic [31:0] br, input logic jmp,
                              input logic [31:0] ins, input logic [31:0] e_pc,
                              input logic [31:0] e_ins, input logic [31:0] e_pp4, input logic e_v);
    vec_t v;
    v.rst = rst; v.sf = sf; v.sd = sd; v.fd = fd; v.src = src; v.br = br; v.jmp = jmp;
    v.ins = ins; v.e_pc = e_pc; v.e_ins = e_ins; v.e_pp4 = e_pp4; v.e_v = e_v;
    return v;
  endfunction

  task automatic chk32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one vector, record its expectation, clock once, then pop and compare.
  task automatic apply(input int idx, input vec_t v);
    exp_t e, got;
    @(negedge clk);
    reset = v.rst; stall_f = v.sf; stall_d = v.sd; flush_d = v.fd;
    pc_src_d = v.src; pc_branch_d = v.br; jump_d = v.jmp; instr_f = v.ins;
    e.pc = v.e_pc; e.ins = v.e_ins; e.pp4 = v.e_pp4; e.v = v.e_v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard step %0d: queue empty, expected 1 entry", idx);
    end else begin
      got = sb.pop_front();
      chk32("pc_f", idx, pc_f, got.pc);
      chk32("instr_d", idx, instr_d, got.ins);
      chk32("pc_plus4_d", idx, pc_plus4_d, got.pp4);
      chk32("valid_d", idx, {31'd0, valid_d}, {31'd0, got.v});
    end
  endtask

  initial begin
    reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_d = 1'b0; pc_branch_d = '0; jump_d = 1'b0; instr_f = '0;

    //              rst sf sd fd src br            jmp ins            e_pc          e_ins         e_pp4         e_v
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h2008_0005, 32'h0,        32'h0,        32'h0,        0)); // reset state
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h2008_0005, 32'h4,        32'h2008_0005,32'h4,        1)); // fetch RESET_PC
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h2008_0005, 32'h8,        32'h2008_0005,32'h8,        1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h40,       0, 32'h2008_0005, 32'h40,       32'h0,        32'h0,        0)); // branch + flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h1111_1111, 32'h44,       32'h1111_1111,32'h44,       1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h1000_0004,0, 32'h9999_9999, 32'h1000_0004,32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h0800_0010, 32'h1000_0008,32'h0800_0010,32'h1000_0008,1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h40,       1, 32'hDEAD_BEEF, 32'h1000_0040,32'h0,        32'h0,        0)); // jump beats branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h2222_2222, 32'h1000_0044,32'h2222_2222,32'h1000_0044,1));
    for (int k = 0; k < 3; k++)                                                                                  // full stall, hold beats flush
      tbl.push_back(mk(0, 1, 1, 1, 1, 32'h80,     1, 32'h3333_3333, 32'h1000_0044,32'h2222_2222,32'h1000_0044,1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 32'h4444_4444, 32'h1000_0044,32'h4444_4444,32'h1000_0048,1)); // PC stall only
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,        0, 32'h5555_5555, 32'h1000_0048,32'h4444_4444,32'h1000_0048,1)); // IF/ID stall only
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC,0, 32'h0,         32'hFFFF_FFFC,32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h6666_6666, 32'h0,        32'h6666_6666,32'h0,        1)); // wrap
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h7777_7777, 32'h4,        32'h7777_7777,32'h4,        1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 32'h0,        1, 32'h8888_8888, 32'h0,        32'h0,        32'h0,        0)); // reset beats stall+jump
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 32'h2008_0005, 32'h4,        32'h2008_0005,32'h4,        1));

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // Hand sequence: redirect offered while PC is stalled is dropped, then taken once released.
    apply(100, mk(0, 1, 0, 1, 1, 32'h100, 0, 32'hAAAA_AAAA, 32'h4,   32'h0,         32'h0,   0));
    apply(101, mk(0, 0, 0, 1, 1, 32'h100, 0, 32'hAAAA_AAAA, 32'h100, 32'h0,         32'h0,   0));
    apply(102, mk(0, 0, 0, 0, 0, 32'h0,   0, 32'hABCD_0000, 32'h104, 32'hABCD_0000, 32'h104, 1));

    // Hand sequence: jump from IF/ID contents under a stalled decode (target uses held instr_d).
    // instr_d = ABCD_0000 -> index 0x3CD_0000, pc_plus4_d = 0x104 -> target 0x0F34_0000.
    apply(103, mk(0, 0, 1, 0, 0, 32'h0,   1, 32'h1234_5678, 32'h0F34_0000, 32'hABCD_0000, 32'h104, 1));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
